// File: rtl/norm_seq.sv
// norm_seq: sequential Euclidean norm of an N-weight signed Q4.5 vector.
// Accumulates the sum of squares one weight per beat, then extracts the
// truncated square root with a restoring one-bit-per-cycle algorithm.
// Optional feature: define NORM_SEQ_SAT_EN to clamp roots above the
// result range to the maximum positive value and raise sat; otherwise
// the root wraps modulo 2^(W-1) and sat stays 0.
module norm_seq #(
  parameter int unsigned N = 20,
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         sat,
  output logic         busy
);

  localparam int unsigned PROD_W  = 2 * W;
  localparam int unsigned ACC_W   = 30;
  localparam int unsigned ROOT_W  = ACC_W / 2;
  localparam int unsigned REM_W   = ROOT_W + 2;
  localparam int unsigned TRIAL_W = REM_W + 3;
  localparam int unsigned CNT_W   = $clog2(N + 1);
  localparam int unsigned ITER_W  = $clog2(ROOT_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    SQRT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state;
  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    beat;
  logic [ACC_W-1:0]    rad;
  logic [ROOT_W-1:0]   root;
  logic [REM_W-1:0]    rem;
  logic [ITER_W-1:0]   iter;

  logic signed [W-1:0]      data_s;
  logic signed [PROD_W-1:0] prod_s;
  logic [PROD_W-1:0]        prod;
  logic [ACC_W-1:0]         acc_sum;

  logic [1:0]          lead;
  logic [TRIAL_W-1:0]  trial;
  logic [ROOT_W-1:0]   root_nxt;
  logic [REM_W-1:0]    rem_nxt;
  logic [W-1:0]        res_nxt;
  logic                sat_nxt;

  // Square of the incoming weight; always non-negative so it fits unsigned.
  always_comb begin
    data_s  = in_data;
    prod_s  = data_s * data_s;
    prod    = prod_s;
    acc_sum = acc + ACC_W'(prod);
  end

  // One restoring square-root step on the top radicand digit pair.
  always_comb begin
    lead     = rad[ACC_W-1 -: 2];
    trial    = {1'b0, rem, lead} - {3'b000, root, 2'b01};
    root_nxt = root;
    rem_nxt  = rem;
    if (!trial[TRIAL_W-1]) begin
      rem_nxt  = trial[REM_W-1:0];
      root_nxt = {root[ROOT_W-2:0], 1'b1};
    end else begin
      rem_nxt  = {rem[REM_W-3:0], lead};
      root_nxt = {root[ROOT_W-2:0], 1'b0};
    end
  end

  // Map the final root onto the Q4.5 result range.
`ifdef NORM_SEQ_SAT_EN
  always_comb begin
    sat_nxt = |root_nxt[ROOT_W-1:W-1];
    res_nxt = sat_nxt ? {1'b0, {(W-1){1'b1}}} : {1'b0, root_nxt[W-2:0]};
  end
`else
  always_comb begin
    sat_nxt = 1'b0;
    res_nxt = {1'b0, root_nxt[W-2:0]};
  end
`endif

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      beat      <= '0;
      rad       <= '0;
      root      <= '0;
      rem       <= '0;
      iter      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      sat       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= '0;
            beat     <= '0;
            state    <= ACC;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ACC: begin
          if (in_valid) begin
            acc  <= acc_sum;
            beat <= beat + CNT_W'(1);
            if (beat == CNT_W'(N - 1)) begin
              state    <= SQRT;
              in_ready <= 1'b0;
              rad      <= acc_sum;
              root     <= '0;
              rem      <= '0;
              iter     <= ITER_W'(ROOT_W - 1);
            end
          end
        end
        SQRT: begin
          rad  <= {rad[ACC_W-3:0], 2'b00};
          rem  <= rem_nxt;
          root <= root_nxt;
          iter <= iter - ITER_W'(1);
          if (iter == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= res_nxt;
            sat       <= sat_nxt;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_norm_seq.sv
// tb_norm_seq: randomized self-checking bench for norm_seq against an
// arithmetic sum-of-squares / integer square-root reference.
module tb_norm_seq;

  localparam int unsigned N = 20;
  localparam int unsigned W = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         sat;
  logic         busy;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  logic signed [W-1:0] wv [N];

  norm_seq #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .sat      (sat),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic longint sumsq();
    longint s = 0;
    for (int i = 0; i < int'(N); i++) begin
      longint x = wv[i];
      s += x * x;
    end
    return s;
  endfunction

  function automatic longint isqrt(input longint a);
    longint r = 0;
    while ((r + 1) * (r + 1) <= a) r++;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full vector: start, N beats (optional gap), wait for result, drain.
  task automatic run_vec(input string tag, input int gap_after, input int gap_len,
                         input int hold, input bit pulse_start);
    longint a, r, er, es;
    int lat, extra;
    a = sumsq();
    r = isqrt(a);
`ifdef NORM_SEQ_SAT_EN
    er = (r > 511) ? 511 : r;
    es = (r > 511) ? 1 : 0;
`else
    er = r % 512;
    es = 0;
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ".ready_after_start"}, in_ready, 1);
    chk({tag, ".busy_after_start"}, busy, 1);
    for (int i = 0; i < int'(N); i++) begin
      in_valid = 1'b1;
      in_data  = wv[i];
      tick();
      in_valid = 1'b0;
      if (i == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          in_data = W'($urandom);
          tick();
        end
        chk({tag, ".ready_in_gap"}, in_ready, 1);
      end
    end
    chk({tag, ".ready_after_last"}, in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      start    = pulse_start && (lat == 3);
      in_valid = 1'($urandom);
      in_data  = W'($urandom);
      tick();
      lat++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    chk({tag, ".latency"}, lat, 15);
    chk({tag, ".result"}, result, er);
    chk({tag, ".sat"}, sat, es);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      tick();
      chk({tag, ".hold_valid"}, out_valid, 1);
      chk({tag, ".hold_result"}, result, er);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".valid_after_hs"}, out_valid, 0);
    chk({tag, ".busy_after_hs"}, busy, 0);
    if (pulse_start) begin
      extra = 0;
      for (int k = 0; k < 25; k++) begin
        tick();
        if (out_valid) extra++;
      end
      chk({tag, ".single_result"}, extra, 0);
    end
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < int'(N); i++) wv[i] = W'(v);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready", in_ready, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.result", result, 0);
    chk("rst.sat", sat, 0);
    chk("rst.busy", busy, 0);
    rst = 1'b0;
    tick();
    chk("idle.in_ready", in_ready, 0);

    fill(32);
    run_vec("ones", -1, 0, 0, 1'b0);
    chk("ones.expect143", result, 143);

    fill(0);
    wv[0] = -10'sd64;
    run_vec("neg64", -1, 0, 0, 1'b0);
    chk("neg64.expect64", result, 64);

    fill(511);
    run_vec("max", -1, 0, 0, 1'b0);
`ifdef NORM_SEQ_SAT_EN
    chk("max.expect511", result, 511);
`else
    chk("max.expect237", result, 237);
`endif

    fill(-512);
    run_vec("min", -1, 0, 0, 1'b0);

    fill(0);
    run_vec("zero", -1, 0, 0, 1'b1);

    fill(32);
    run_vec("backpr", 6, 3, 5, 1'b0);
    chk("backpr.expect143", result, 143);

    // Abort a vector after 10 beats with reset.
    fill(32);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = wv[i];
      tick();
    end
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("abort.in_ready", in_ready, 0);
    chk("abort.out_valid", out_valid, 0);
    chk("abort.busy", busy, 0);
    begin
      int seen = 0;
      for (int k = 0; k < 30; k++) begin
        in_valid = 1'($urandom);
        tick();
        if (out_valid || in_ready) seen++;
      end
      in_valid = 1'b0;
      chk("abort.quiet", seen, 0);
    end
    run_vec("fresh", -1, 0, 0, 1'b0);
    chk("fresh.expect143", result, 143);

    for (int t = 0; t < 10; t++) begin
      int sel = int'($urandom_range(0, 2));
      for (int i = 0; i < int'(N); i++) begin
        if (sel == 0) wv[i] = W'($urandom);
        else if (sel == 1) wv[i] = W'($urandom_range(0, 15)) - 10'sd8;
        else wv[i] = ($urandom_range(0, 1) != 0) ? 10'sd511 : -10'sd512;
      end
      run_vec($sformatf("rnd%0d", t), int'($urandom_range(0, N - 2)),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/norm_seq.md
# norm_seq

Sequential, handshaked replacement for the combinational weight-norm path. Accepts a 20-weight vector one signed Q4.5 word per beat, accumulates the sum of squares, then runs a one-bit-per-cycle restoring integer square root. Returns the exact truncated Euclidean norm in Q4.5. Sits between the weight store and the weight-normalisation stage, time-sharing one multiplier and one subtractor instead of 20 multipliers and a lookup ladder.

## Interface
- N, 20: weights per vector (2..32)
- W, 10: weight and result width, signed, 5 fractional bits
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a vector; honoured only in IDLE
- in_valid  in  1  in_data holds a weight
- in_ready  out  1  block accepts a weight this cycle
- in_data  in  W  signed Q4.5 weight
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  consumer accepts result
- result  out  W  norm, Q4.5, MSB always 0
- sat  out  1  root exceeded 511; qualified by out_valid
- busy  out  1  state is not IDLE

## Operation
- States: IDLE, ACC, SQRT, DONE.
- IDLE:
  - Outputs are idle.
  - start=1 clears the accumulator (30 bits) and the beat counter, then moves to ACC.
- ACC:
  - in_ready=1.
  - Each beat with in_valid & in_ready adds in_data*in_data to the accumulator. The product is signed 10x10 into a 20-bit unsigned value, zero-extended to 30 bits.
  - The beat counter increments on each accepted beat.
  - On the Nth accepted beat, move to SQRT. Load the radicand from the accumulator, clear the root (15 bits) and the remainder (17 bits), and set the iteration counter to 14.
- SQRT:
  - Restoring digit-by-digit square root, one root bit per cycle, exactly 15 cycles.
  - Each step: trial = {rem, radicand top 2 bits} − {root, 2'b01}.
    - If trial ≥ 0: rem = trial, root = {root, 1}.
    - Else: rem = {rem, radicand top 2 bits}, root = {root, 0}.
    - Shift the radicand left by 2.
  - After the iteration with counter 0, move to DONE.
  - Final root = floor(sqrt(acc)). Because squares carry 10 fractional bits, the root is directly Q.5.
- DONE:
  - out_valid=1; result and sat are stable.
  - out_valid & out_ready returns to IDLE. The next start is accepted in the following cycle.
- start outside IDLE is ignored. in_valid outside ACC is ignored, since in_ready=0 there.
- The maximum accumulator value is N·512² = 5,242,880 at N=20, so there is no accumulator overflow for N ≤ 32.

## Timing
- Reset values: state=IDLE, in_ready=0, out_valid=0, result=0, sat=0, busy=0, and all internal registers 0.
- Reset dominates every other input in the same cycle. Reset mid-ACC or mid-SQRT aborts the vector, and no out_valid is produced for it.
- start seen in IDLE at edge t puts the block in ACC, with in_ready=1 in cycle t+1.
- Last beat accepted at edge t: SQRT occupies cycles t+1..t+15, and out_valid=1 from cycle t+16.
- Minimum vector-to-result latency with continuous in_valid is N+16 cycles after start.
- in_valid gaps stall ACC with no state change. out_ready=0 holds DONE with result unchanged indefinitely.
- in_ready is a registered state decode, with no combinational path from in_valid. out_valid is registered.

## Configuration
- NORM_SEQ_SAT_EN defined:
  - A root greater than 511 gives result=511 (0x1FF) and sat=1.
  - Otherwise result={0, root[8:0]} and sat=0.
- NORM_SEQ_SAT_EN undefined:
  - result={0, root[8:0]} always, i.e. wrap modulo 512.
  - sat is tied to 0.

## Test plan
- All 20 weights = 32 (1.0): acc=20480 → result=143 (4.46875), sat=0. out_valid arrives exactly 16 cycles after the 20th beat.
- w0 = −64, rest 0: acc=4096 → result=64 (2.0), sat=0. A negative weight squares correctly.
- All weights = 511:
  - acc=5,222,420, root=2285.
  - With NORM_SEQ_SAT_EN: result=511, sat=1.
  - Without NORM_SEQ_SAT_EN: result=237, sat=0.
- All weights 0 → result=0, sat=0. start pulsed again during SQRT is ignored, and exactly one result is produced.
- Backpressure:
  - in_valid low for 3 cycles between beats 7 and 8: the weight count is still 20 and the result is unchanged.
  - out_ready low for 5 cycles: out_valid and result are held. Handshake on cycle 6, then busy=0 on the next cycle.
- rst asserted after beat 10 of a vector: next cycle state=IDLE, in_ready=0, out_valid=0. A fresh vector of 20×32 then gives result=143.
